// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and default widths.
// fetch_entry_t is what the instruction buffer stores: {pc, instr}.
package fetch_unit_pkg;

   localparam int          XLEN             = 32;
   localparam int          IMEM_AW          = 12;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          FETCH_BUF_DEPTH  = 2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Instruction fetch is always word aligned; low byte-offset bits are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry circular FIFO of fetched {pc, instr} pairs feeding decode.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_buffer
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t mem_q [FETCH_BUF_DEPTH];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   count_q;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop & (count_q != 2'd0);
   // When full, a push is only legal alongside a pop: it lands in the slot being vacated.
   assign do_push = push & ((count_q != 2'd2) | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to imem, and buffers the
// one-cycle-latency responses in a 2-entry FIFO presented to decode via valid/ready.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = XLEN,
   parameter int                    ADDR_WIDTH = IMEM_AW,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] imem_address,
   input  logic [DATA_WIDTH-1:0] imem_read_data,
   input  logic                  imem_read_data_valid,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready
);

   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] inflight_pc_q;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [1:0]            count;
   logic [2:0]            occupancy;
   logic                  pop;
   logic                  push;
   logic                  rewind;
   logic                  issue;
   fetch_entry_t          push_entry;
   fetch_entry_t          head;

   assign fetch_pc     = redirect_valid ? align_pc(redirect_pc) : pc_q;
   assign imem_address = fetch_pc[ADDR_WIDTH+1:2];

   assign instr_valid = (count != 2'd0) & ~redirect_valid;
   assign pop         = instr_valid & instr_ready;

   // A redirect discards whatever response arrives in the same cycle.
   assign push   = inflight_q &  imem_read_data_valid & ~redirect_valid;
   assign rewind = inflight_q & ~imem_read_data_valid & ~redirect_valid;

   // Slots committed after this cycle; keeping this under 2 guarantees the FIFO
   // always has room for the response of every read we issue.
   assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = redirect_valid | (~rewind & (occupancy < 3'd2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (issue) begin
         inflight_q    <= 1'b1;
         inflight_pc_q <= fetch_pc;
         pc_q          <= fetch_pc + DATA_WIDTH'(4);
      end else begin
         inflight_q <= 1'b0;
         if (rewind) begin
            pc_q <= inflight_pc_q;
         end
      end
   end

   assign push_entry = '{pc: inflight_pc_q, instr: imem_read_data};

   fetch_buffer u_fetch_buffer (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head       (head)
   );

   assign instr    = head.instr;
   assign instr_pc = head.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the word address into imem. It captures imem's one-cycle-latency read data and presents `{pc, instr}` to decode through a valid/ready handshake. A 2-entry instruction buffer absorbs decode stalls without losing in-flight reads, and a redirect port (branch/jump/trap) flushes the stage and restarts fetch at a new PC.

## Interface

Parameters:
- `DATA_WIDTH`: default `` `DATA_WIDTH `` (32). Instruction and PC width.
- `ADDR_WIDTH`: default `` `IMEM_ADDR_WIDTH ``. imem word-address width.
- `RESET_PC`: default `` `RESET_PC `` (32'h0000_0000). Byte address fetched first after reset.

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `imem_address`  out  ADDR_WIDTH  word address to imem, equal to `fetch_pc[ADDR_WIDTH+1:2]`
- `imem_read_data`  in  DATA_WIDTH  imem read data for the address issued last cycle
- `imem_read_data_valid`  in  1  imem response valid for last cycle's issue
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  DATA_WIDTH  new byte PC; bits [1:0] ignored and treated as 0
- `instr_valid`  out  1  buffer head is valid for decode
- `instr`  out  DATA_WIDTH  head instruction
- `instr_pc`  out  DATA_WIDTH  byte PC of head instruction
- `instr_ready`  in  1  decode accepts head this cycle

## Operation

State:
- `pc_q`: next PC to issue.
- `inflight_q`: 1 bit.
- `inflight_pc_q`: PC of the in-flight read.
- 2-entry FIFO of `{pc, instr}` with `count` 0..2.

Rules:
- `fetch_pc = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q`.
- `pop = instr_valid & instr_ready`.
- `instr_valid = (count != 0) & ~redirect_valid`. Nothing transfers in a redirect cycle.
- `issue = redirect_valid | (count + inflight_q - pop < 2)`.
- On issue: `inflight_q<=1`, `inflight_pc_q<=fetch_pc`, `pc_q<=fetch_pc+4`. PC wraps modulo 2^32. The imem index wraps modulo 2^ADDR_WIDTH by truncation.
- With no issue: `inflight_q<=0`, `pc_q` holds. `imem_address` still follows `fetch_pc`, and that read data is ignored.
- Response, when `inflight_q` is set:
  - If `imem_read_data_valid`: push `{inflight_pc_q, imem_read_data}`.
  - Otherwise: drop the response and rewind `pc_q<=inflight_pc_q`. The rewind takes priority over this cycle's issue, and no issue occurs that cycle.
- Redirect:
  - FIFO cleared (`count<=0`).
  - Any response arriving this cycle is discarded.
  - `redirect_pc` is issued this same cycle.
  - Redirect wins over push, pop and rewind.
- Invariant: `count + inflight_q <= 2`. The FIFO never overflows, so no push is ever dropped for lack of space.
- Simultaneous push and pop: `count` unchanged. The new entry is enqueued behind the popped head.

## Timing

- Reset values (async assert):
  - `pc_q=RESET_PC`, `inflight_q=0`, `inflight_pc_q=0`, `count=0`.
  - FIFO storage 0.
  - `instr_valid=0`, `instr=0`, `instr_pc=0`.
  - `imem_address=RESET_PC[ADDR_WIDTH+1:2]`.
- Reset mid-operation: all in-flight and buffered work is discarded.
- First issue happens in the first cycle after `rst` deasserts (cycle 0).
- Latency from issue to head:
  - Issue at cycle N, imem data at N+1, pushed at the N+1 edge.
  - `instr_valid` at N+2 when the FIFO is empty.
  - The same 2-cycle latency applies after a redirect.
- Throughput is 1 instruction/cycle sustained with `instr_ready` held high.
- Outputs are registered FIFO head. There is no combinational path from `imem_read_data` to `instr`.
- `instr`/`instr_pc` hold stable while `instr_valid & ~instr_ready`.

## Structure

- Add to the shared `types.sv`:
  - `` `RESET_PC ``
  - `typedef struct packed {logic [DATA_WIDTH-1:0] pc; logic [DATA_WIDTH-1:0] instr;} fetch_entry_t`
- Sub-module `fetch_buffer`: 2-entry FIFO of `fetch_entry_t`.
  - Ports: `push`, `pop`, `flush`, `count`, and head.
  - Async active-high reset.
  - Flush has priority over push and pop.
- `fetch_unit` holds the PC/in-flight logic and instantiates `fetch_buffer`.

## Test plan

- **Reset, then `instr_ready=1`:** `imem_address` = 0,1,2,…; the stream starts with `instr_valid` at cycle 2 with `instr_pc`=0x0, then 0x4, 0x8 each cycle; `instr` matches preloaded words.
- **Decode stall:** hold `instr_ready=0` from cycle 3 for 5 cycles. Then `count` = 2 and issue stops. The head stays `instr_pc`=0x4 and stable. On release, 0x4, 0x8, 0xC follow with no gap and no loss.
- **Redirect:** pulse `redirect_valid`, `redirect_pc`=0x103 while 2 entries are buffered and one is in flight. Then `instr_valid`=0 that cycle, `imem_address`=0x40, and the next `instr_pc`=0x100 appears 2 cycles later. No stale PCs are delivered.
- **Retry:** drive `imem_read_data_valid=0` for the response to PC 0x8. The stage re-issues 0x8. The delivered sequence is 0x0, 0x4, 0x8, 0xC with no duplicates or gaps.
- **Wrap:** redirect to 0xFFFF_FFFC. The stream delivers `instr_pc` 0xFFFF_FFFC then 0x0. `imem_address` wraps to all-ones then 0.
- **Async reset mid-stream:** `count` = 2, assert `rst`. Outputs clear immediately without waiting for a clock edge. After release, fetch restarts at `RESET_PC`.
